// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU Avalon-MM bus arbiter.
package cpu_bus_pkg;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 32;

    // Instruction fetches always read the whole word.
    localparam logic [3:0] FETCH_BYTEENABLE = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_I,
        GRANT_D
    } arb_state_t;

endpackage

// File: rtl/bus_timeout_counter.sv
// Saturating waitrequest counter with a sticky hang flag; the flag clears only on reset.
module bus_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic waiting,
    input  logic done,
    output logic bus_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wait_count;

    // Counting stops at LIMIT so a long hang cannot wrap the count back below the threshold.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_count  <= '0;
            bus_timeout <= 1'b0;
        end else if (done) begin
            wait_count <= '0;
        end else if (waiting && (wait_count != LIMIT)) begin
            wait_count <= wait_count + CNT_W'(1);
            if (wait_count + CNT_W'(1) == LIMIT) begin
                bus_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/avalon_mem_arbiter.sv
// Two-requester Avalon-MM arbiter (fetch + data) with registered bus outputs.
// Optional macro ARB_ROUND_ROBIN_EN: alternate on simultaneous requests instead of data-first.
module avalon_mem_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W         = DEFAULT_ADDR_W,
    parameter int DATA_W         = DEFAULT_DATA_W,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_read,
    input  logic [ADDR_W-1:0]   if_address,
    output logic [DATA_W-1:0]   if_readdata,
    output logic                if_waitrequest,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [ADDR_W-1:0]   d_address,
    input  logic [DATA_W-1:0]   d_writedata,
    input  logic [DATA_W/8-1:0] d_byteenable,
    output logic [DATA_W-1:0]   d_readdata,
    output logic                d_waitrequest,
    output logic [ADDR_W-1:0]   address,
    output logic                read,
    output logic                write,
    output logic [DATA_W-1:0]   writedata,
    output logic [DATA_W/8-1:0] byteenable,
    input  logic                waitrequest,
    input  logic [DATA_W-1:0]   readdata,
    output logic                bus_timeout
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t state, next_state;
    logic       d_request;
    logic       pick_data;
    logic       granted;

    assign d_request = d_read | d_write;
    assign granted   = (state != IDLE);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_data;

    // On a tie the requester that was not served last wins; a lone request always wins.
    assign pick_data = d_request & (~if_read | ~last_grant_data);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_data <= 1'b0;
        end else if (state == IDLE && next_state != IDLE) begin
            last_grant_data <= (next_state == GRANT_D);
        end
    end
`else
    assign pick_data = d_request;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (pick_data) begin
                    next_state = GRANT_D;
                end else if (if_read) begin
                    next_state = GRANT_I;
                end
            end
            GRANT_I, GRANT_D: begin
                if (!waitrequest) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Bus signals are captured once on entry to a grant and then held until completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            address    <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            writedata  <= '0;
            byteenable <= '0;
        end else if (state == IDLE) begin
            if (next_state == GRANT_D) begin
                address    <= d_address;
                write      <= d_write;
                read       <= d_read & ~d_write;
                writedata  <= d_writedata;
                byteenable <= d_byteenable;
            end else if (next_state == GRANT_I) begin
                address    <= if_address;
                write      <= 1'b0;
                read       <= 1'b1;
                byteenable <= BE_W'(FETCH_BYTEENABLE);
            end
        end else if (!waitrequest) begin
            read  <= 1'b0;
            write <= 1'b0;
        end
    end

    assign if_readdata    = (state == GRANT_I) ? readdata : '0;
    assign d_readdata     = (state == GRANT_D) ? readdata : '0;
    assign if_waitrequest = if_read   & ~((state == GRANT_I) & ~waitrequest);
    assign d_waitrequest  = d_request & ~((state == GRANT_D) & ~waitrequest);

    bus_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk        (clk),
        .reset      (reset),
        .waiting    (granted & waitrequest),
        .done       (granted & ~waitrequest),
        .bus_timeout(bus_timeout)
    );

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Directed self-checking bench for avalon_mem_arbiter (TIMEOUT_CYCLES=8).
module tb_avalon_mem_arbiter;
    import cpu_bus_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_read;
    logic [31:0] if_address;
    logic [31:0] if_readdata;
    logic        if_waitrequest;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_address;
    logic [31:0] d_writedata;
    logic [3:0]  d_byteenable;
    logic [31:0] d_readdata;
    logic        d_waitrequest;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        bus_timeout;

    int checks   = 0;
    int failures = 0;
    bit first_data;

    avalon_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset),
        .if_read(if_read), .if_address(if_address),
        .if_readdata(if_readdata), .if_waitrequest(if_waitrequest),
        .d_read(d_read), .d_write(d_write), .d_address(d_address),
        .d_writedata(d_writedata), .d_byteenable(d_byteenable),
        .d_readdata(d_readdata), .d_waitrequest(d_waitrequest),
        .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable),
        .waitrequest(waitrequest), .readdata(readdata),
        .bus_timeout(bus_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1; if_read = 0; if_address = 0; d_read = 0; d_write = 0;
        d_address = 0; d_writedata = 0; d_byteenable = 0; waitrequest = 0; readdata = 0;
        tick(); tick();
        checkOutput("rst_read", read, 0);
        checkOutput("rst_write", write, 0);
        checkOutput("rst_address", address, 0);
        checkOutput("rst_writedata", writedata, 0);
        checkOutput("rst_byteenable", byteenable, 0);
        checkOutput("rst_timeout", bus_timeout, 0);
        reset = 1'b0;
        tick();

        // Test 1: single fetch, zero wait states
        if_read = 1; if_address = 32'h04; readdata = 32'h1111_2222; waitrequest = 0;
        #1;
        checkOutput("t1_idle_stall", if_waitrequest, 1);
        checkOutput("t1_idle_read", read, 0);
        tick();
        checkOutput("t1_read", read, 1);
        checkOutput("t1_address", address, 32'h04);
        checkOutput("t1_be", byteenable, 4'hF);
        checkOutput("t1_write", write, 0);
        checkOutput("t1_if_wait", if_waitrequest, 0);
        checkOutput("t1_if_rdata", if_readdata, 32'h1111_2222);
        tick();
        if_read = 0;
        #1;
        checkOutput("t1_read_drop", read, 0);

        // Test 2: write held off by three wait cycles
        d_write = 1; d_address = 32'h20; d_writedata = 32'hDEAD_BEEF; d_byteenable = 4'b0011;
        waitrequest = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            checkOutput("t2_write", write, 1);
            checkOutput("t2_address", address, 32'h20);
            checkOutput("t2_wdata", writedata, 32'hDEAD_BEEF);
            checkOutput("t2_be", byteenable, 4'b0011);
            checkOutput("t2_d_wait_hi", d_waitrequest, 1);
            tick();
        end
        waitrequest = 0;
        #1;
        checkOutput("t2_write_c4", write, 1);
        checkOutput("t2_address_c4", address, 32'h20);
        checkOutput("t2_d_wait_lo", d_waitrequest, 0);
        tick();
        d_write = 0;
        #1;
        checkOutput("t2_write_drop", write, 0);
        checkOutput("t2_no_timeout", bus_timeout, 0);

        // Test 3: simultaneous fetch and data reads (last grant was data)
`ifdef ARB_ROUND_ROBIN_EN
        first_data = 0;
`else
        first_data = 1;
`endif
        if_read = 1; if_address = 32'h08; d_read = 1; d_address = 32'h40; d_byteenable = 4'hF;
        readdata = 32'hAAAA_0001;
        tick();
        checkOutput("t3_first_read", read, 1);
        checkOutput("t3_first_addr", address, first_data ? 32'h40 : 32'h08);
        checkOutput("t3_first_d_wait", d_waitrequest, first_data ? 1'b0 : 1'b1);
        checkOutput("t3_first_if_wait", if_waitrequest, first_data ? 1'b1 : 1'b0);
        if (first_data) checkOutput("t3_d_rdata", d_readdata, 32'hAAAA_0001);
        else            checkOutput("t3_if_rdata", if_readdata, 32'hAAAA_0001);
        tick();
        if (first_data) d_read = 0; else if_read = 0;
        #1;
        checkOutput("t3_gap_read", read, 0);
        readdata = 32'hBBBB_0002;
        tick();
        checkOutput("t3_second_read", read, 1);
        checkOutput("t3_second_addr", address, first_data ? 32'h08 : 32'h40);
        if (first_data) checkOutput("t3_if_rdata2", if_readdata, 32'hBBBB_0002);
        else            checkOutput("t3_d_rdata2", d_readdata, 32'hBBBB_0002);
        tick();
        if_read = 0; d_read = 0;
        #1;
        checkOutput("t3_done_read", read, 0);

        // Test 6: read and write together issue only the write
        d_read = 1; d_write = 1; d_address = 32'h30; d_writedata = 32'h1234_5678; d_byteenable = 4'hF;
        tick();
        checkOutput("t6_write", write, 1);
        checkOutput("t6_read", read, 0);
        checkOutput("t6_address", address, 32'h30);
        checkOutput("t6_d_wait", d_waitrequest, 0);
        tick();
        d_read = 0; d_write = 0;
        #1;
        checkOutput("t6_write_drop", write, 0);

        // Test 4: hung slave sets the sticky timeout after 8 wait cycles
        if_read = 1; if_address = 32'h100; waitrequest = 1;
        tick();
        for (int i = 0; i < 7; i++) tick();
        checkOutput("t4_timeout_at7", bus_timeout, 0);
        checkOutput("t4_read_held", read, 1);
        tick();
        checkOutput("t4_timeout_at8", bus_timeout, 1);
        tick(); tick();
        checkOutput("t4_timeout_sat", bus_timeout, 1);
        checkOutput("t4_addr_held", address, 32'h100);
        waitrequest = 0;
        #1;
        checkOutput("t4_if_wait_lo", if_waitrequest, 0);
        tick();
        if_read = 0;
        #1;
        checkOutput("t4_read_drop", read, 0);
        checkOutput("t4_sticky", bus_timeout, 1);
        tick();
        checkOutput("t4_sticky2", bus_timeout, 1);

        // Test 5: reset during a stalled data grant
        d_read = 1; d_address = 32'h50; waitrequest = 1;
        tick();
        checkOutput("t5_read_pre", read, 1);
        reset = 1;
        tick();
        checkOutput("t5_read", read, 0);
        checkOutput("t5_write", write, 0);
        checkOutput("t5_state", dut.state, IDLE);
        checkOutput("t5_timeout", bus_timeout, 0);
        checkOutput("t5_address", address, 0);
        reset = 0; d_read = 0; waitrequest = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
